// File: rtl/dot_pkg.sv
// Shared constants and reader FSM encoding for the dotProduct vector memories.
package dot_pkg;

  localparam int DOT_DATA_WIDTH = 8;
  localparam int DOT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } rdState_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO whose head falls through to the incoming word when empty,
// so a read return can be presented in the same cycle it arrives.
module rd_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  rdPtr_q, wrPtr_q;
  logic [1:0]            count_q, count_d;
  logic                  empty, doPop, bypass, doWrite, doRead;

  assign empty   = (count_q == 2'd0);
  assign valid_o = !empty || push_i;
  assign head_o  = !empty ? mem_q[rdPtr_q] : (push_i ? data_i : '0);
  assign count_o = count_q;

  // A word arriving into an empty FIFO and taken immediately is never stored.
  assign doPop   = pop_i && valid_o;
  assign bypass  = empty && push_i && doPop;
  assign doWrite = push_i && !bypass;
  assign doRead  = doPop && !empty;
  assign count_d = count_q + {1'b0, doWrite} - {1'b0, doRead};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= !wrPtr_q;
      end
      if (doRead) begin
        rdPtr_q <= !rdPtr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dot_vec_reader.sv
// Read sequencer: walks an address window of a 1-cycle-latency memory and
// streams the words out on valid/ready with a last flag on the final element.
module dot_vec_reader
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = DOT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DOT_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  rdState_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issueRem_q, issueRem_d;
  logic [LEN_WIDTH-1:0]  deliverRem_q, deliverRem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifoCount, occupancy;
  logic                  issue, handshake;

  rd_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (out_ready),
    .data_i  (mem_data_out),
    .valid_o (out_valid),
    .head_o  (out_data),
    .count_o (fifoCount)
  );

  // Never have more words stored or in flight than the FIFO can absorb.
  assign occupancy = fifoCount + {1'b0, inflight_q};
  assign issue     = (state_q == ST_FETCH) && (occupancy < 2'd2);
  assign handshake = out_valid && out_ready;

  assign mem_read_en      = issue;
  assign mem_read_address = addr_q;
  assign busy             = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
  assign done             = (state_q == ST_DONE);
  assign out_last         = out_valid && (deliverRem_q == LEN_WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issueRem_d   = issueRem_q;
    deliverRem_d = deliverRem_q;
    inflight_d   = issue;
    if (handshake) begin
      deliverRem_d = deliverRem_q - LEN_WIDTH'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d      = ST_FETCH;
            addr_d       = base_addr;
            issueRem_d   = length;
            deliverRem_d = length;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (issue) begin
          addr_d     = addr_q + ADDR_WIDTH'(1);
          issueRem_d = issueRem_q - LEN_WIDTH'(1);
          if (issueRem_q == LEN_WIDTH'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (handshake && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issueRem_q   <= '0;
      deliverRem_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issueRem_q   <= issueRem_d;
      deliverRem_q <= deliverRem_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule

// File: tb/tb_dot_vec_reader.sv
// Randomized self-checking bench for dot_vec_reader against a queue-based model
// of the expected word stream and cycle timing.
module tb_dot_vec_reader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, mem_read_en;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic [DW-1:0] memModel [DEPTH];
  int checkCount = 0;
  int passCount = 0;

  always #5 clk = ~clk;

  // Memory with one-cycle registered read; returns junk when not reading.
  always @(posedge clk) begin
    if (mem_read_en) mem_data_out <= memModel[mem_read_address];
    else             mem_data_out <= DW'($urandom);
  end

  dot_vec_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_read_en      (mem_read_en),
    .mem_read_address (mem_read_address),
    .mem_data_out     (mem_data_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rden"}, mem_read_en, 0);
    checkOutput({tag, "_raddr"}, mem_read_address, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_data"}, out_data, 0);
    checkOutput({tag, "_last"}, out_last, 0);
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic applyStimulus(input int base, input int len, input int readyMode,
                               input int abortAfter, input bit pokeStart, output bit aborted);
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] prevData;
    int issued, delivered, cycle;
    bit doneSeen, prevStall, lenDone;
    aborted = 0;
    doneSeen = 0;
    prevStall = 0;
    prevData = '0;
    issued = 0;
    delivered = 0;
    cycle = 0;
    for (int i = 0; i < len; i++) expQ.push_back(memModel[(base + i) % DEPTH]);

    @(negedge clk);
    start = 1'b1;
    base_addr = AW'(base);
    length = LW'(len);
    out_ready = 1'b0;
    #1 checkOutput("idleBusy", busy, 0);

    while (!doneSeen && !aborted && cycle < 400) begin
      @(negedge clk);
      cycle++;
      start = 1'b0;
      if (pokeStart && delivered == len) begin
        start = 1'b1;
        length = LW'(3);
      end
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cycle % 3 == 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      lenDone = (delivered == len);
      checkOutput("done", done, lenDone);
      checkOutput("busy", busy, !lenDone);
      if (lenDone) begin
        doneSeen = 1;
      end else begin
        if (cycle == 1) checkOutput("firstRead", mem_read_en, 1);
        if (cycle == 2) checkOutput("firstValid", out_valid, 1);
        if (mem_read_en) begin
          checkOutput("overIssue", issued < len, 1);
          checkOutput("credit", (issued - delivered) < 2, 1);
          checkOutput("readAddr", mem_read_address, (base + issued) % DEPTH);
          issued++;
        end
        if (prevStall) begin
          checkOutput("stallValid", out_valid, 1);
          checkOutput("stallData", out_data, prevData);
        end
        checkOutput("last", out_last, out_valid && (delivered == len - 1));
        if (out_valid && out_ready) begin
          checkOutput("data", out_data, expQ[delivered]);
          if (readyMode == 0) checkOutput("hsCycle", cycle, delivered + 2);
          delivered++;
        end
        prevStall = out_valid && !out_ready;
        prevData = out_data;
        if (abortAfter > 0 && delivered == abortAfter) aborted = 1;
      end
    end

    if (!doneSeen && !aborted) checkOutput("timeout", 0, 1);
    if (doneSeen) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b0;
      #1;
      checkOutput("postDone_done", done, 0);
      checkOutput("postDone_busy", busy, 0);
      checkOutput("postDone_rden", mem_read_en, 0);
    end
  endtask

  initial begin
    bit aborted;
    for (int i = 0; i < DEPTH; i++) memModel[i] = DW'(i + 'h10);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 checkIdleZero("reset");
    @(negedge clk);
    rst_n = 1'b0;

    applyStimulus(2, 4, 0, 0, 0, aborted);
    applyStimulus(14, 4, 0, 0, 0, aborted);
    applyStimulus(0, 6, 1, 0, 0, aborted);
    applyStimulus(5, 0, 0, 0, 1, aborted);
    applyStimulus(0, 16, 0, 0, 0, aborted);
    applyStimulus(3, 16, 2, 0, 1, aborted);

    applyStimulus(0, 8, 0, 2, 0, aborted);
    checkOutput("abortTaken", aborted, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1 checkIdleZero("midReset");
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 checkOutput("noDoneAfterReset", done, 0);
    end
    applyStimulus(0, 2, 0, 0, 0, aborted);

    for (int i = 0; i < DEPTH; i++) memModel[i] = DW'($urandom);
    for (int t = 0; t < 25; t++) begin
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                    $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), aborted);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dot_vec_reader.md
Name: dot_vec_reader

Overview:
Read-side sequencer for the dotProduct vector memories. On a start pulse it walks a contiguous address window of a memory block with 1-cycle registered read latency. It presents each fetched word on a valid/ready stream, with a last flag on the final element. It is the initiator that drives a memory's read_en/read_address and consumes its data_out, and it feeds the dot-product MAC.

Parameters:
DATA_WIDTH, 8, width of a memory word and of out_data
ADDR_WIDTH, 4, memory address width; addresses wrap modulo 2^ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, width of length; allows a full-memory read of 2^ADDR_WIDTH words

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-high (asserted = 1), despite the name
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first read address, captured with start
length  input  LEN_WIDTH  number of words to read, captured with start
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse after the last element handshakes (or after zero-length start)
mem_read_en  output  1  to memory read_en
mem_read_address  output  ADDR_WIDTH  to memory read_address
mem_data_out  input  DATA_WIDTH  from memory data_out; valid in the cycle after mem_read_en
out_valid  output  1  stream valid
out_ready  input  1  stream ready from consumer
out_data  output  DATA_WIDTH  stream data
out_last  output  1  high with the final element of a transfer

Behaviour:
- Interface: one clock; reset is synchronous and active-high. While rst_n=1 at a clock edge, all state clears: FSM to IDLE; busy, done, mem_read_en, out_valid, out_last = 0; mem_read_address, out_data = 0; FIFO and counters empty. Reset mid-transfer aborts it; an in-flight read's returning data is discarded; no done pulse.
- FSM states: IDLE, FETCH, FLUSH, DONE.
- IDLE: start=1 and length!=0 -> FETCH. Capture base_addr into the address counter, length into the issue and deliver counters. start=1 and length=0 -> DONE; no memory reads.
- FETCH: set mem_read_en=1 and mem_read_address=addr when credit is available, i.e. (fifo_count + inflight) < 2. On each issue, addr increments with wrap (0xF+1 -> 0x0 for ADDR_WIDTH=4) and issue_remaining decrements. When issue_remaining reaches 0 -> FLUSH.
- Read return: inflight is set in the cycle after an issue. The FIFO pushes mem_data_out on that cycle's edge only. mem_data_out is ignored at all other times, because memory holds stale data when read_en=0.
- FIFO: 2-entry rd_skid_fifo. Head drives out_data/out_valid. Pop on out_valid & out_ready. Push and pop in the same cycle are legal at any occupancy; count is unchanged.
- out_last = out_valid & (deliver_remaining == 1). deliver_remaining decrements on each handshake.
- FLUSH: no issues. The handshake with out_last -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- busy = 1 in FETCH and FLUSH.
- start is ignored outside IDLE, including during DONE.
- Latency: start accepted at edge T. First mem_read_en is in cycle T+1. First out_valid is in cycle T+2.
- With out_ready held high: one element per cycle, and done is in the cycle after the last handshake.
- Backpressure: out_ready=0 stalls issue within 2 cycles. No data loss; out_data and out_valid stay stable while stalled.
- Words are delivered in address order; no reordering or duplication.

Decomposition:
- Shared package/include dot_pkg: FSM state encoding (IDLE=2'd0, FETCH=2'd1, FLUSH=2'd2, DONE=2'd3) and the default DATA_WIDTH/ADDR_WIDTH constants shared with the memory blocks.
- One sub-module, rd_skid_fifo: 2-deep FIFO with push, pop, count, head output.
- FSM, address counter, issue/deliver counters and credit logic stay in dot_vec_reader.

Test Plan:
- Memory preloaded mem[i]=i+0x10; start with base=2, length=4, out_ready=1 -> out_data 0x12,0x13,0x14,0x15 on consecutive cycles from T+2; out_last only with 0x15; done one cycle later.
- Wrap: base=0xE, length=4 -> reads at addresses E,F,0,1; data 0x1E,0x1F,0x10,0x11.
- Backpressure: length=6 with out_ready toggling 1,0,0,1,... -> no more than 2 reads outstanding; out_data stable while stalled; all 6 words delivered in order.
- length=0 -> mem_read_en never asserted; done pulses at T+1; busy stays 0.
- Full read: length=16 -> 16 words delivered, counters handle LEN_WIDTH=5 correctly, done once.
- Reset mid-transfer: rst_n=1 after 2 handshakes -> all outputs 0 next cycle; no done pulse. A following start with base=0, length=2 delivers 0x10, 0x11 with no stale word.
